// File: rtl/axi_lite_sram_pkg.sv
// Shared AXI-Lite definitions: response codes and responder FSM encoding.
// Used by the SRAM responder and by the core-side AXI master.
package axi_lite_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4
    } axi_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int LAT_W = 4;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_sram_sram_1rw.sv
// Single-port DEPTH x 32 storage, per-byte write enable, registered read.
// Contents are deliberately never reset.
module sram_1rw #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-masked write and read-old-data register on every enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite SRAM responder: one transaction at a time, LAT wait cycles
// before each response, SLVERR outside [BASE, BASE + 4*DEPTH).
module axi_lite_sram #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int                LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i
);

    import axi_lite_sram_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW1   = ADDR_W + 1;

    // One extra bit so BASE + 4*DEPTH cannot wrap
    localparam logic [AW1-1:0] LO = {1'b0, BASE};
    localparam logic [AW1-1:0] HI = LO + AW1'(4 * DEPTH);

    localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT);

    axi_state_t r_state;
    axi_state_t w_next;

    logic [LAT_W-1:0] r_cnt;
    logic             r_live;
    logic             r_err;

    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic w_arready;
    logic w_awready;
    logic w_ar_hs;
    logic w_aw_hs;
    logic w_r_hs;
    logic w_b_hs;

    logic [ADDR_W-1:0] w_addr;
    logic [AW1-1:0]    w_addr_x;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_rng;
    logic              w_unused_bits;

    logic        w_mem_en;
    logic [3:0]  w_mem_we;
    logic [31:0] w_mem_rdata;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: reads win over writes, wait states only when LAT > 0
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ar_hs) begin
                    w_next = (LAT_V == '0) ? ST_RD_RESP : ST_RD_WAIT;
                end else if (w_aw_hs) begin
                    w_next = (LAT_V == '0) ? ST_WR_RESP : ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (w_r_hs) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Ready outputs: held low until the first edge after reset release
    always_comb begin
        w_arready = 1'b0;
        w_awready = 1'b0;
        if (r_live && r_state == ST_IDLE) begin
            w_arready = 1'b1;
            w_awready = !arvalid_i && awvalid_i && wvalid_i;
        end
    end

    assign arready_o = w_arready;
    assign awready_o = w_awready;
    assign wready_o  = w_awready;

    assign w_ar_hs = arvalid_i && w_arready;
    assign w_aw_hs = w_awready;
    assign w_r_hs  = r_rvalid && rready_i;
    assign w_b_hs  = r_bvalid && bready_i;

    // Only one handshake can occur per cycle, so one decoder serves both
    assign w_addr   = w_ar_hs ? araddr_i : awaddr_i;
    assign w_addr_x = {1'b0, w_addr};
    assign w_in_rng = (w_addr_x >= LO) && (w_addr_x < HI);
    assign w_off    = w_addr - BASE;
    assign w_idx    = w_off[IDX_W+1:2];

    assign w_unused_bits = ^{w_off[ADDR_W-1:IDX_W+2], w_off[1:0]};

    assign w_mem_en = (w_ar_hs || w_aw_hs) && w_in_rng;
    assign w_mem_we = (w_aw_hs && w_in_rng) ? wstrb_i : 4'b0000;

    sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .i_clk   (clk_i),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_idx),
        .i_wdata (wdata_i[31:0]),
        .o_rdata (w_mem_rdata)
    );

    // Ready gate: first cycle after reset release stays not-ready
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Latency counter and range-error flag captured at each handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_ar_hs || w_aw_hs) begin
            r_cnt <= LAT_V;
            r_err <= !w_in_rng;
        end else if ((r_state == ST_RD_WAIT || r_state == ST_WR_WAIT)
                     && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Response registers: loaded once when valid rises, held until accepted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end else if ((r_state == ST_RD_WAIT && r_cnt == '0)
                         || (r_state == ST_RD_RESP && !r_rvalid)) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_err ? '0 : DATA_W'(w_mem_rdata);
                r_rresp  <= resp_code(r_err);
            end
            if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end else if ((r_state == ST_WR_WAIT && r_cnt == '0)
                         || (r_state == ST_WR_RESP && !r_bvalid)) begin
                r_bvalid <= 1'b1;
                r_bresp  <= resp_code(r_err);
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign rresp_o  = r_rresp;
    assign bvalid_o = r_bvalid;
    assign bresp_o  = r_bresp;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram: LAT=1 instance plus a LAT=0 instance.
// Each scenario task drives its own stimulus and checks inline.
module tb_axi_lite_sram;

    logic clk;
    logic rst;
    logic sel;

    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_bready;

    logic        a_arready, a_rvalid, a_awready, a_wready, a_bvalid;
    logic [31:0] a_rdata;
    logic [1:0]  a_rresp, a_bresp;
    logic        z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
    logic [31:0] z_rdata;
    logic [1:0]  z_rresp, z_bresp;

    logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp, o_bresp;

    int errs;
    int checks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    axi_lite_sram #(.LAT(1)) u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .araddr_i  (m_araddr),
        .arvalid_i (m_arvalid & ~sel),
        .arready_o (a_arready),
        .rdata_o   (a_rdata),
        .rresp_o   (a_rresp),
        .rvalid_o  (a_rvalid),
        .rready_i  (m_rready & ~sel),
        .awaddr_i  (m_awaddr),
        .awvalid_i (m_awvalid & ~sel),
        .awready_o (a_awready),
        .wdata_i   (m_wdata),
        .wstrb_i   (m_wstrb),
        .wvalid_i  (m_wvalid & ~sel),
        .wready_o  (a_wready),
        .bresp_o   (a_bresp),
        .bvalid_o  (a_bvalid),
        .bready_i  (m_bready & ~sel)
    );

    axi_lite_sram #(.LAT(0)) u_dut0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .araddr_i  (m_araddr),
        .arvalid_i (m_arvalid & sel),
        .arready_o (z_arready),
        .rdata_o   (z_rdata),
        .rresp_o   (z_rresp),
        .rvalid_o  (z_rvalid),
        .rready_i  (m_rready & sel),
        .awaddr_i  (m_awaddr),
        .awvalid_i (m_awvalid & sel),
        .awready_o (z_awready),
        .wdata_i   (m_wdata),
        .wstrb_i   (m_wstrb),
        .wvalid_i  (m_wvalid & sel),
        .wready_o  (z_wready),
        .bresp_o   (z_bresp),
        .bvalid_o  (z_bvalid),
        .bready_i  (m_bready & sel)
    );

    assign o_arready = sel ? z_arready : a_arready;
    assign o_rvalid  = sel ? z_rvalid  : a_rvalid;
    assign o_rdata   = sel ? z_rdata   : a_rdata;
    assign o_rresp   = sel ? z_rresp   : a_rresp;
    assign o_awready = sel ? z_awready : a_awready;
    assign o_wready  = sel ? z_wready  : a_wready;
    assign o_bvalid  = sel ? z_bvalid  : a_bvalid;
    assign o_bresp   = sel ? z_bresp   : a_bresp;

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit ok;
        ok   = 1'b0;
        data = '0;
        resp = 2'b11;
        lat  = -1;
        @(posedge clk); #1;
        m_araddr  = addr;
        m_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_arready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        if (!ok) return;
        for (int i = 0; i <= 40; i++) begin
            if (o_rvalid) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) return;
        data = o_rdata;
        resp = o_rresp;
        m_rready = 1'b1;
        @(posedge clk); #1;
        m_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output int lat);
        bit ok;
        ok   = 1'b0;
        resp = 2'b11;
        lat  = -1;
        @(posedge clk); #1;
        m_awaddr  = addr;
        m_wdata   = data;
        m_wstrb   = strb;
        m_awvalid = 1'b1;
        m_wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_awready && o_wready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        if (!ok) return;
        for (int i = 0; i <= 40; i++) begin
            if (o_bvalid) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) return;
        resp = o_bresp;
        m_bready = 1'b1;
        @(posedge clk); #1;
        m_bready = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        repeat (3) @(negedge clk);
        outs = {a_arready, a_awready, a_wready, a_rvalid, a_bvalid,
                a_rresp, a_bresp, z_arready, z_awready, z_wready,
                z_rvalid, z_bvalid, z_rresp};
        checks++;
        if (outs !== 16'h0) begin
            errs++;
            $display("FAIL reset_ctrl: got %h need 0000", outs);
        end
        checks++;
        if (a_rdata !== 32'h0 || z_rdata !== 32'h0) begin
            errs++;
            $display("FAIL reset_rdata: got %h/%h need 0", a_rdata, z_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_arready !== 1'b0) begin
            errs++;
            $display("FAIL release_arready_early: got %b need 0", a_arready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_arready !== 1'b1) begin
            errs++;
            $display("FAIL release_arready: got %b need 1", a_arready);
        end
    endtask

    task automatic test_full_word();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, l);
        checks++;
        if (l !== 2 || r !== 2'b00) begin
            errs++;
            $display("FAIL wr_full: lat %0d resp %b need 2/00", l, r);
        end
        do_read(32'h8000_0010, d, r, l);
        checks++;
        if (l !== 2 || r !== 2'b00 || d !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL rd_full: lat %0d resp %b data %h need 2/00/deadbeef",
                     l, r, d);
        end
    endtask

    task automatic test_partial();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, r, l);
        do_read(32'h8000_0010, d, r, l);
        checks++;
        if (d !== 32'hDE22_BE44 || r !== 2'b00) begin
            errs++;
            $display("FAIL rd_partial: data %h resp %b need de22be44/00", d, r);
        end
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, r, l);
        checks++;
        if (r !== 2'b00 || l !== 2) begin
            errs++;
            $display("FAIL wr_zero_strb: resp %b lat %0d need 00/2", r, l);
        end
        do_read(32'h8000_0013, d, r, l);
        checks++;
        if (d !== 32'hDE22_BE44) begin
            errs++;
            $display("FAIL rd_after_zero_strb: data %h need de22be44", d);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        do_write(32'h8000_0000, 32'h0123_4567, 4'hF, r, l);
        do_write(32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, r, l);
        checks++;
        if (r !== 2'b00) begin
            errs++;
            $display("FAIL wr_last_word: resp %b need 00", r);
        end
        do_read(32'h7FFF_FFFC, d, r, l);
        checks++;
        if (r !== 2'b10 || d !== 32'h0 || l !== 2) begin
            errs++;
            $display("FAIL rd_below: resp %b data %h lat %0d need 10/0/2",
                     r, d, l);
        end
        do_write(32'h8000_4000, 32'hCAFE_F00D, 4'hF, r, l);
        checks++;
        if (r !== 2'b10 || l !== 2) begin
            errs++;
            $display("FAIL wr_above: resp %b lat %0d need 10/2", r, l);
        end
        do_read(32'h8000_4000, d, r, l);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            errs++;
            $display("FAIL rd_above: resp %b data %h need 10/0", r, d);
        end
        do_read(32'h8000_0000, d, r, l);
        checks++;
        if (d !== 32'h0123_4567 || r !== 2'b00) begin
            errs++;
            $display("FAIL word0_intact: data %h need 01234567", d);
        end
        do_read(32'h8000_3FFC, d, r, l);
        checks++;
        if (d !== 32'hA5A5_5A5A || r !== 2'b00) begin
            errs++;
            $display("FAIL rd_last_word: data %h resp %b need a5a55a5a/00",
                     d, r);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        logic [31:0] rd;
        logic [1:0]  r;
        int          l;
        int ar_t, r_t, aw_t, b_t;
        bit both;
        ar_t = -1; r_t = -1; aw_t = -1; b_t = -1;
        both = 1'b0;
        rd   = '0;
        @(posedge clk); #1;
        m_araddr  = 32'h8000_0010;
        m_arvalid = 1'b1;
        m_awaddr  = 32'h8000_0020;
        m_wdata   = 32'h55AA_55AA;
        m_wstrb   = 4'hF;
        m_awvalid = 1'b1;
        m_wvalid  = 1'b1;
        m_rready  = 1'b1;
        m_bready  = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (o_rvalid && o_bvalid) both = 1'b1;
            if (o_arready && m_arvalid && ar_t < 0) ar_t = t;
            if (o_awready && m_awvalid && aw_t < 0) aw_t = t;
            if (o_rvalid && r_t < 0) begin
                r_t = t;
                rd  = o_rdata;
            end
            if (o_bvalid && b_t < 0) b_t = t;
            @(posedge clk); #1;
            if (ar_t == t) m_arvalid = 1'b0;
            if (aw_t == t) begin
                m_awvalid = 1'b0;
                m_wvalid  = 1'b0;
            end
            if (b_t >= 0) break;
        end
        m_arvalid = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_rready  = 1'b0;
        m_bready  = 1'b0;
        checks++;
        if (ar_t !== 0 || r_t !== 3 || aw_t !== 4 || b_t !== 7) begin
            errs++;
            $display("FAIL conflict_order: ar %0d r %0d aw %0d b %0d need 0/3/4/7",
                     ar_t, r_t, aw_t, b_t);
        end
        checks++;
        if (both !== 1'b0) begin
            errs++;
            $display("FAIL conflict_overlap: got %b need 0", both);
        end
        checks++;
        if (rd !== 32'hDE22_BE44) begin
            errs++;
            $display("FAIL conflict_rdata: got %h need de22be44", rd);
        end
        do_read(32'h8000_0020, d, r, l);
        checks++;
        if (d !== 32'h55AA_55AA) begin
            errs++;
            $display("FAIL conflict_wr_data: got %h need 55aa55aa", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [31:0] d0;
        logic [1:0]  r;
        int          l;
        bit ok;
        bit bad;
        ok  = 1'b0;
        bad = 1'b0;
        d0  = '0;
        @(posedge clk); #1;
        m_araddr  = 32'h8000_0010;
        m_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_arready) break;
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_rvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        d0 = o_rdata;
        m_araddr  = 32'h8000_0000;
        m_arvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!o_rvalid || o_rdata !== d0 || o_rresp !== 2'b00
                || o_arready !== 1'b0) bad = 1'b1;
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        checks++;
        if (!ok || d0 !== 32'hDE22_BE44) begin
            errs++;
            $display("FAIL bp_rdata: valid %b data %h need 1/de22be44", ok, d0);
        end
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL bp_stable: outputs moved under rready=0 (got 1 need 0)");
        end
        m_rready = 1'b1;
        @(posedge clk); #1;
        m_rready = 1'b0;
        checks++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b1) begin
            errs++;
            $display("FAIL bp_release: rvalid %b arready %b need 0/1",
                     o_rvalid, o_arready);
        end
        sel = 1'b1;
        do_write(32'h8000_0008, 32'h0BAD_CAFE, 4'hF, r, l);
        checks++;
        if (l !== 1 || r !== 2'b00) begin
            errs++;
            $display("FAIL lat0_wr: lat %0d resp %b need 1/00", l, r);
        end
        do_read(32'h8000_0008, d, r, l);
        checks++;
        if (l !== 1 || d !== 32'h0BAD_CAFE || r !== 2'b00) begin
            errs++;
            $display("FAIL lat0_rd: lat %0d data %h need 1/0badcafe", l, d);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        bit bad;
        bad = 1'b0;
        @(posedge clk); #1;
        m_araddr  = 32'h8000_0010;
        m_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_arready) break;
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_rvalid || o_arready) bad = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_rvalid) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL mid_reset_abort: response seen (got 1 need 0)");
        end
        checks++;
        if (o_arready !== 1'b1) begin
            errs++;
            $display("FAIL mid_reset_arready: got %b need 1", o_arready);
        end
        do_read(32'h8000_0010, d, r, l);
        checks++;
        if (l !== 2 || d !== 32'hDE22_BE44 || r !== 2'b00) begin
            errs++;
            $display("FAIL mid_reset_read: lat %0d data %h resp %b need 2/de22be44/00",
                     l, d, r);
        end
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        rst       = 1'b0;
        sel       = 1'b0;
        m_araddr  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awaddr  = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        test_reset();
        test_full_word();
        test_partial();
        test_range();
        test_conflict();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
